// File: rtl/boruss_datapath_core.sv
// rtl/boruss_datapath_core.sv - parametrised CPU datapath: register file, writeback handshake, flags, timed loads, LED view (optional macro ZERO_REG_EN)
module boruss_datapath_core #(
    parameter int DATA_W      = 8,
    parameter int NUM_REGS    = 4,
    parameter int STEP_DIV    = 8388608,
    parameter int MEM_TIMEOUT = 15,
    localparam int RIDX_W     = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              reset,
    output logic              step_tick,
    input  logic [RIDX_W-1:0] rd_a_idx,
    input  logic [RIDX_W-1:0] rd_b_idx,
    output logic [DATA_W-1:0] rd_a_data,
    output logic [DATA_W-1:0] rd_b_data,
    input  logic              wb_valid,
    output logic              wb_ready,
    input  logic [RIDX_W-1:0] wb_dest,
    input  logic [1:0]        wb_sel,
    input  logic [DATA_W-1:0] wb_alu,
    input  logic [DATA_W-1:0] wb_imm,
    input  logic              flags_we,
    input  logic [2:0]        flags_in,
    output logic [2:0]        flags,
    output logic              mem_req,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              load_err,
    input  logic              err_clr,
    input  logic [RIDX_W-1:0] view_sel,
    output logic [DATA_W-1:0] led_out
);

    localparam int CNT_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam int TO_W  = $clog2(MEM_TIMEOUT + 1);

    localparam logic [1:0] SEL_ALU = 2'd0;
    localparam logic [1:0] SEL_IMM = 2'd1;
    localparam logic [1:0] SEL_MEM = 2'd2;

    typedef enum logic {IDLE, LOAD} state_t;

    state_t              state;
    state_t              state_next;
    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [CNT_W-1:0]    step_cnt;
    logic [TO_W-1:0]     to_cnt;
    logic [RIDX_W-1:0]   load_dest;

    logic                wr_en;
    logic [RIDX_W-1:0]   wr_idx;
    logic [DATA_W-1:0]   wr_data;
    logic                load_start;
    logic                timeout_hit;
    logic                wr_allowed;

    assign rd_a_data = regs[rd_a_idx];
    assign rd_b_data = regs[rd_b_idx];

`ifdef ZERO_REG_EN
    // Register 0 never leaves its reset value of zero, so reads and the LED view see 0.
    assign wr_allowed = (wr_idx != '0);
`else
    assign wr_allowed = 1'b1;
`endif

    // Step generator: free-running divider, tick registered one cycle after terminal count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            step_cnt  <= '0;
            step_tick <= 1'b0;
        end else begin
            step_tick <= (step_cnt == CNT_W'(STEP_DIV - 1));
            if (step_cnt == CNT_W'(STEP_DIV - 1)) begin
                step_cnt <= '0;
            end else begin
                step_cnt <= step_cnt + 1'b1;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state, handshake outputs and register-file write selection.
    always_comb begin
        state_next  = state;
        wb_ready    = 1'b0;
        mem_req     = 1'b0;
        wr_en       = 1'b0;
        wr_idx      = wb_dest;
        wr_data     = wb_alu;
        load_start  = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            IDLE: begin
                wb_ready = 1'b1;
                if (wb_valid) begin
                    case (wb_sel)
                        SEL_ALU: begin
                            wr_en   = 1'b1;
                            wr_data = wb_alu;
                        end
                        SEL_IMM: begin
                            wr_en   = 1'b1;
                            wr_data = wb_imm;
                        end
                        SEL_MEM: begin
                            load_start = 1'b1;
                            state_next = LOAD;
                        end
                        default: ;
                    endcase
                end
            end
            LOAD: begin
                mem_req = 1'b1;
                wr_idx  = load_dest;
                if (mem_ack) begin
                    wr_en      = 1'b1;
                    wr_data    = mem_rdata;
                    state_next = IDLE;
                end else if (to_cnt == TO_W'(MEM_TIMEOUT - 1)) begin
                    timeout_hit = 1'b1;
                    state_next  = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Load bookkeeping: capture destination on entry, count cycles waiting for ack.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            load_dest <= '0;
            to_cnt    <= '0;
        end else if (load_start) begin
            load_dest <= wb_dest;
            to_cnt    <= '0;
        end else if (state == LOAD && !mem_ack) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    // Register file write port.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en && wr_allowed) begin
            regs[wr_idx] <= wr_data;
        end
    end

    // Flags register, loaded independently of the writeback path.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flags <= '0;
        end else if (flags_we) begin
            flags <= flags_in;
        end
    end

    // Sticky load error; a new timeout beats a simultaneous clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            load_err <= 1'b0;
        end else if (timeout_hit) begin
            load_err <= 1'b1;
        end else if (err_clr) begin
            load_err <= 1'b0;
        end
    end

    // LED view sampled only on step ticks so it changes at human-visible rate.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            led_out <= '0;
        end else if (step_tick) begin
            led_out <= regs[view_sel];
        end
    end

endmodule

// File: doc/boruss_datapath_core.md
Name: boruss_datapath_core

Overview:
Parametrised successor of the 8-bit four-register CPU datapath. It generalises data width and register count, and uses a single-domain clock-enable step generator instead of a derived slow clock. Adds a writeback handshake with ALU, immediate and memory-load sources, a flags register, a load timeout with sticky error, and a selectable LED/debug view of any register. Sits between the FSM/ALU and the memory controller in the CPU top.

Parameters:
DATA_W, 8, register/data width in bits (>=4)
NUM_REGS, 4, number of general registers (power of two, 2..16); index width RIDX_W = $clog2(NUM_REGS)
STEP_DIV, 8388608, clk cycles per step_tick (>=1; 1 = tick every cycle)
MEM_TIMEOUT, 15, max cycles waiting for mem_ack before aborting a load (>=1)

Ports:
clk  in  1  system clock, all state on posedge clk
reset  in  1  asynchronous, active-low
step_tick  out  1  one-clk-wide pulse every STEP_DIV cycles; used as the FSM clock enable
rd_a_idx  in  RIDX_W  read port A register index
rd_b_idx  in  RIDX_W  read port B register index
rd_a_data  out  DATA_W  combinational regs[rd_a_idx]
rd_b_data  out  DATA_W  combinational regs[rd_b_idx]
wb_valid  in  1  writeback request
wb_ready  out  1  writeback accept
wb_dest  in  RIDX_W  destination register
wb_sel  in  2  source: 0 = ALU, 1 = immediate, 2 = memory, 3 = reserved
wb_alu  in  DATA_W  ALU result
wb_imm  in  DATA_W  immediate value
flags_we  in  1  load flags register
flags_in  in  3  {N,C,Z} from ALU
flags  out  3  registered {N,C,Z}
mem_req  out  1  load request, held until ack or timeout
mem_ack  in  1  load data valid (1-cycle pulse)
mem_rdata  in  DATA_W  load data
load_err  out  1  sticky load-timeout error
err_clr  in  1  clears load_err
view_sel  in  RIDX_W  register shown on led_out
led_out  out  DATA_W  registered regs[view_sel], updated only on step_tick

Behaviour:
- Reset (async assert, sync release): all regs = 0, flags = 0, step counter = 0, step_tick = 0, FSM = IDLE, mem_req = 0, load_err = 0, led_out = 0.
- Step generator:
  - counter runs 0..STEP_DIV-1 and wraps.
  - step_tick is registered, high for the one cycle after the counter equals STEP_DIV-1.
  - STEP_DIV = 1: step_tick is constant 1 after the first post-reset cycle.
- Read ports: pure combinational. No write bypass; a same-cycle read returns the old value.
- FSM states: IDLE, LOAD.
- IDLE:
  - wb_ready = 1.
  - Handshake fires on wb_valid & wb_ready.
  - sel 0: regs[wb_dest] <= wb_alu at that edge; stay IDLE.
  - sel 1: regs[wb_dest] <= wb_imm at that edge; stay IDLE.
  - sel 2: latch wb_dest, clear timeout counter, go LOAD.
  - sel 3: accepted and dropped; no state change.
- LOAD:
  - wb_ready = 0, mem_req = 1.
  - mem_ack: regs[latched dest] <= mem_rdata, mem_req drops next cycle, go IDLE.
  - Timeout: counter increments each cycle without ack. At MEM_TIMEOUT cycles with no ack, set load_err, leave the register unchanged, go IDLE.
  - mem_ack on the same cycle as the timeout: ack wins, no error.
- Back-to-back: a new writeback is accepted the cycle after returning to IDLE (ALU/IMM can be accepted every cycle).
- flags: flags <= flags_in when flags_we, in any state, independent of writeback.
- load_err: set has priority over err_clr in the same cycle.
- led_out: led_out <= regs[view_sel] on cycles where step_tick = 1; otherwise holds.
- Reset asserted mid-LOAD: immediate return to IDLE, mem_req = 0, pending load discarded.

Optional Feature:
ZERO_REG_EN.
- Defined: register 0 is hardwired to zero. Reads return 0, writebacks to index 0 are accepted (handshake completes, loads still issue mem_req) but discarded, and led_out shows 0 when view_sel = 0.
- Undefined: register 0 is an ordinary register.

Test Plan:
- STEP_DIV = 4, release reset -> step_tick pulses once every 4 clk, high exactly 1 cycle; first pulse 4 cycles after release.
- wb_sel = 1, dest = 2, imm = 0xA5; then rd_a_idx = 2 -> rd_a_data = 0xA5 on the next cycle, old value in the same cycle.
- wb_sel = 2, dest = 1; mem_ack with 0x3C after 3 cycles -> wb_ready low for 3 cycles, mem_req high throughout, reg1 = 0x3C, IDLE the following cycle.
- Load with no ack, MEM_TIMEOUT = 15 -> after 15 cycles load_err = 1, reg unchanged, wb_ready = 1; err_clr pulse -> load_err = 0; ack on the 15th cycle -> no error.
- flags_we with {1,0,1} during LOAD, then reset mid-LOAD -> flags = 3'b101 before reset, all state 0 after, mem_req drops immediately.
- ZERO_REG_EN defined, imm 0xFF to reg0 -> rd_a_data = 0, handshake completes; undefined -> 0xFF; view_sel = 0 led_out matches after next step_tick.
